fifo_deq_unpack: RTL and testbench
==================================

FIFO_DEQ_UNPACK -- requirements
Module: fifo_deq_unpack

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter: LSB_FIRST, default 1, lane order (1: bits [31:0] sent first; 0: bits [127:96] sent first).
REQ-003 Port: CLK  input  1  clock, all state updates on posedge.
REQ-004 Port: RST  input  1  synchronous active-high reset.
REQ-005 Port: in$deq__ENA  output  1  dequeue strobe to upstream 128-bit FIFO.
REQ-006 Port: in$deq__RDY  input  1  upstream FIFO holds an element.
REQ-007 Port: in$first  input  128  upstream head element, valid when in$deq__RDY=1.
REQ-008 Port: out$enq__ENA  output  1  word-valid strobe to downstream 32-bit sink.
REQ-009 Port: out$enq$v  output  32  word being enqueued.
REQ-010 Port: out$enq__RDY  input  1  downstream can accept a word this cycle.

Function
REQ-011 Block SHALL be the reader end of a 128-bit guarded FIFO: drains elements via deq/first and re-emits each as four 32-bit words via enq.
REQ-012 State SHALL be IDLE or SEND, plus 128-bit holding register buf and 2-bit lane index idx.
REQ-013 in$first SHALL be sampled only in a cycle where in$deq__ENA=1; upstream first__RDY is not used.
REQ-014 in$deq__ENA SHALL = !RST & in$deq__RDY & (state==IDLE | (state==SEND & idx==3 & out$enq__RDY)).
REQ-015 out$enq__ENA SHALL = !RST & state==SEND & out$enq__RDY; never asserted in IDLE.
REQ-016 out$enq$v SHALL = buf lane idx (LSB_FIRST=1: buf[32*idx+31 : 32*idx]; LSB_FIRST=0: buf[127-32*idx : 96-32*idx]); 0 in IDLE.
REQ-017 IDLE + deq: buf<=in$first, idx<=0, state<=SEND; first word visible next cycle (latency 1).
REQ-018 SEND + out$enq__ENA with idx<3: idx<=idx+1, state stays SEND.
REQ-019 SEND + out$enq__ENA with idx==3 and in$deq__RDY=1: buf<=in$first, idx<=0, stay SEND (back-to-back, no bubble).
REQ-020 SEND + out$enq__ENA with idx==3 and in$deq__RDY=0: idx<=0, state<=IDLE.
REQ-021 SEND with out$enq__RDY=0: buf, idx, state SHALL hold; no word lost or duplicated.
REQ-022 Sustained throughput SHALL be 1 word/cycle (one 128-bit element per 4 cycles) when both sides ready.
REQ-023 in$deq__ENA SHALL never assert when in$deq__RDY=0; out$enq__ENA never when out$enq__RDY=0.
REQ-024 idx arithmetic SHALL be modulo 4; idx never advances without out$enq__ENA.

Reset
REQ-025 While RST=1 at posedge: state<=IDLE, idx<=0, buf<=0.
REQ-026 While RST=1: in$deq__ENA=0, out$enq__ENA=0, out$enq$v=0 combinationally.
REQ-027 RST mid-element SHALL discard remaining lanes; upstream element already dequeued is not recovered.
REQ-028 First deq possible in first cycle with RST=0 and in$deq__RDY=1.

Structure
REQ-029 Shared package SHALL hold ELEM_W=128, WORD_W=32, LANES=4 and state enum {IDLE, SEND}.
REQ-030 Single flat module; no sub-module required (optional lane mux function in the package).

Verification
REQ-031 Single element: in$first=0x44444444_33333333_22222222_11111111, sink always ready -> deq ENA 1 cycle, then out$enq$v 0x11111111,0x22222222,0x33333333,0x44444444 on 4 consecutive cycles, then IDLE.
REQ-032 Back-to-back: two elements queued, sink ready -> 8 words on 8 consecutive cycles, second in$deq__ENA coincident with 4th word.
REQ-033 Backpressure: out$enq__RDY low for 3 cycles after word 1 -> out$enq__ENA 0 those cycles, word 2 (0x22222222) emitted once when RDY returns, no duplicates.
REQ-034 LSB_FIRST=0, same element -> order 0x44444444,0x33333333,0x22222222,0x11111111.
REQ-035 Reset after word 2 of element A -> ENAs 0 during RST, state IDLE; next element B emits its 4 words cleanly, no A remnants.
REQ-036 Random upstream/downstream ready (1000 elements) -> scoreboard word stream equals concatenated lane sequence, assertions REQ-023 never fire.

Source files
------------

// File: rtl/fifo_deq_unpack_pkg.sv
// Shared definitions for the 128-bit to 32-bit FIFO unpacker: element and word
// geometry, the two-state controller encoding and the lane select helper.
package fifo_deq_unpack_pkg;

  localparam int ELEM_W = 128;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Pick the 32-bit word for send position idx. In MSB-first order the
  // physical lane is 3-idx, which for a 2-bit index is its bitwise inverse.
  function automatic logic [WORD_W-1:0] lane_sel(input logic [ELEM_W-1:0] elem,
                                                 input logic [1:0]        idx,
                                                 input logic              lsb_first);
    logic [1:0] lane;
    lane = lsb_first ? idx : ~idx;
    return elem[int'(lane)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/fifo_deq_unpack.sv
// Reader end of a 128-bit guarded FIFO. Each dequeued element is held and
// re-emitted as four 32-bit words, one per cycle the sink is ready. When the
// last word leaves, the next element is dequeued in the same cycle so a
// continuous stream runs at one word per clock without bubbles.
module fifo_deq_unpack
  import fifo_deq_unpack_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                in_deq__ENA,
  input  logic                in_deq__RDY,
  input  logic [ELEM_W-1:0]   in_first,
  output logic                out_enq__ENA,
  output logic [WORD_W-1:0]   out_enq_v,
  input  logic                out_enq__RDY
);

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [1:0]          idx_q, idx_d;

  logic                last_lane;
  logic                deq_ena;
  logic                enq_ena;

  // Handshake strobes, output word and next-state selection.
  always_comb begin
    last_lane = (idx_q == 2'd3);
    enq_ena   = !RST && (state_q == SEND) && out_enq__RDY;
    deq_ena   = !RST && in_deq__RDY &&
                ((state_q == IDLE) || ((state_q == SEND) && last_lane && out_enq__RDY));

    out_enq_v = '0;
    if (!RST && (state_q == SEND)) begin
      out_enq_v = lane_sel(elem_q, idx_q, LSB_FIRST);
    end

    state_d = state_q;
    elem_d  = elem_q;
    idx_d   = idx_q;
    if (deq_ena) begin
      // Covers both the IDLE pickup and the back-to-back reload on lane 3.
      elem_d  = in_first;
      idx_d   = 2'd0;
      state_d = SEND;
    end else if (enq_ena) begin
      idx_d = idx_q + 2'd1;
      if (last_lane) begin
        state_d = IDLE;
      end
    end

    in_deq__ENA  = deq_ena;
    out_enq__ENA = enq_ena;
  end

  // State, holding register and lane index; reset clears all three.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      elem_q  <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_fifo_deq_unpack.sv
// Bench for fifo_deq_unpack: an LSB-first and an MSB-first instance share one
// stimulus. Directed per-cycle vectors cover reset, single element, back-to-back,
// backpressure and mid-element reset; a randomized run with a word scoreboard
// follows.
module tb_fifo_deq_unpack;

  logic         CLK = 1'b0;
  logic         rst;
  logic         deq_rdy;
  logic [127:0] first;
  logic         enq_rdy;

  logic         deq_ena0, enq_ena0;
  logic [31:0]  v0;
  logic         deq_ena1, enq_ena1;
  logic [31:0]  v1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fifo_deq_unpack #(.LSB_FIRST(1'b1)) dut_lsb (
    .CLK(CLK), .RST(rst),
    .in_deq__ENA(deq_ena0), .in_deq__RDY(deq_rdy), .in_first(first),
    .out_enq__ENA(enq_ena0), .out_enq_v(v0), .out_enq__RDY(enq_rdy)
  );

  fifo_deq_unpack #(.LSB_FIRST(1'b0)) dut_msb (
    .CLK(CLK), .RST(rst),
    .in_deq__ENA(deq_ena1), .in_deq__RDY(deq_rdy), .in_first(first),
    .out_enq__ENA(enq_ena1), .out_enq_v(v1), .out_enq__RDY(enq_rdy)
  );

  typedef struct {
    logic         rst;
    logic         drdy;
    logic [127:0] first;
    logic         erdy;
    logic         edeq;
    logic         eenq;
    logic [31:0]  ev;
    logic [31:0]  evm;
  } vec_t;

  vec_t vecs[$];

  localparam logic [127:0] E1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] E2 = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] E3 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] EX = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;

  function automatic void add(input logic r, input logic dr, input logic [127:0] f,
                              input logic er, input logic edq, input logic enq,
                              input logic [31:0] ev, input logic [31:0] evm);
    vec_t t;
    t.rst = r; t.drdy = dr; t.first = f; t.erdy = er;
    t.edeq = edq; t.eenq = enq; t.ev = ev; t.evm = evm;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  localparam int N_ELEM = 1000;
  logic [127:0] elems[N_ELEM];
  logic [31:0]  exp0[$];
  logic [31:0]  exp1[$];
  int           elem_i;
  int           words0, words1;

  initial begin
    rst = 1'b1; deq_rdy = 1'b0; first = '0; enq_rdy = 1'b0;

    //   rst drdy first erdy | deq enq  lsb-word      msb-word
    // reset state
    add(1, 1, E1, 1,  0, 0, 32'h0,        32'h0);
    add(1, 1, E1, 1,  0, 0, 32'h0,        32'h0);
    // single element, sink always ready
    add(0, 1, E1, 1,  1, 0, 32'h0,        32'h0);
    add(0, 0, EX, 1,  0, 1, 32'h11111111, 32'h44444444);
    add(0, 0, EX, 1,  0, 1, 32'h22222222, 32'h33333333);
    add(0, 0, EX, 1,  0, 1, 32'h33333333, 32'h22222222);
    add(0, 0, EX, 1,  0, 1, 32'h44444444, 32'h11111111);
    add(0, 0, EX, 1,  0, 0, 32'h0,        32'h0);
    // back-to-back: second deq coincides with fourth word
    add(0, 1, E2, 1,  1, 0, 32'h0,        32'h0);
    add(0, 1, E3, 1,  0, 1, 32'h55555555, 32'h88888888);
    add(0, 1, E3, 1,  0, 1, 32'h66666666, 32'h77777777);
    add(0, 1, E3, 1,  0, 1, 32'h77777777, 32'h66666666);
    add(0, 1, E3, 1,  1, 1, 32'h88888888, 32'h55555555);
    add(0, 0, EX, 1,  0, 1, 32'hAAAAAAAA, 32'hDDDDDDDD);
    add(0, 0, EX, 1,  0, 1, 32'hBBBBBBBB, 32'hCCCCCCCC);
    add(0, 0, EX, 1,  0, 1, 32'hCCCCCCCC, 32'hBBBBBBBB);
    add(0, 0, EX, 1,  0, 1, 32'hDDDDDDDD, 32'hAAAAAAAA);
    // backpressure for 3 cycles after word 1
    add(0, 1, E1, 1,  1, 0, 32'h0,        32'h0);
    add(0, 0, EX, 1,  0, 1, 32'h11111111, 32'h44444444);
    add(0, 0, EX, 0,  0, 0, 32'h22222222, 32'h33333333);
    add(0, 0, EX, 0,  0, 0, 32'h22222222, 32'h33333333);
    add(0, 0, EX, 0,  0, 0, 32'h22222222, 32'h33333333);
    add(0, 0, EX, 1,  0, 1, 32'h22222222, 32'h33333333);
    add(0, 0, EX, 1,  0, 1, 32'h33333333, 32'h22222222);
    add(0, 0, EX, 1,  0, 1, 32'h44444444, 32'h11111111);
    // lane 3 stalled while upstream ready: no deq until the sink takes it
    add(0, 1, E2, 1,  1, 0, 32'h0,        32'h0);
    add(0, 0, EX, 1,  0, 1, 32'h55555555, 32'h88888888);
    add(0, 0, EX, 1,  0, 1, 32'h66666666, 32'h77777777);
    add(0, 0, EX, 1,  0, 1, 32'h77777777, 32'h66666666);
    add(0, 1, E1, 0,  0, 0, 32'h88888888, 32'h55555555);
    add(0, 1, E1, 1,  1, 1, 32'h88888888, 32'h55555555);
    add(0, 0, EX, 1,  0, 1, 32'h11111111, 32'h44444444);
    add(0, 0, EX, 1,  0, 1, 32'h22222222, 32'h33333333);
    // reset after word 2, then a clean element
    add(1, 1, E2, 1,  0, 0, 32'h0,        32'h0);
    add(0, 1, E3, 1,  1, 0, 32'h0,        32'h0);
    add(0, 0, EX, 1,  0, 1, 32'hAAAAAAAA, 32'hDDDDDDDD);
    add(0, 0, EX, 1,  0, 1, 32'hBBBBBBBB, 32'hCCCCCCCC);
    add(0, 0, EX, 1,  0, 1, 32'hCCCCCCCC, 32'hBBBBBBBB);
    add(0, 0, EX, 1,  0, 1, 32'hDDDDDDDD, 32'hAAAAAAAA);
    add(0, 0, EX, 1,  0, 0, 32'h0,        32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      rst = vecs[i].rst; deq_rdy = vecs[i].drdy;
      first = vecs[i].first; enq_rdy = vecs[i].erdy;
      #1;
      chk($sformatf("vec%0d lsb deq_ena", i), 32'(deq_ena0), 32'(vecs[i].edeq));
      chk($sformatf("vec%0d lsb enq_ena", i), 32'(enq_ena0), 32'(vecs[i].eenq));
      chk($sformatf("vec%0d lsb word", i),    v0,            vecs[i].ev);
      chk($sformatf("vec%0d msb deq_ena", i), 32'(deq_ena1), 32'(vecs[i].edeq));
      chk($sformatf("vec%0d msb enq_ena", i), 32'(enq_ena1), 32'(vecs[i].eenq));
      chk($sformatf("vec%0d msb word", i),    v1,            vecs[i].evm);
    end

    // Randomized readiness on both sides with a word-order scoreboard.
    for (int e = 0; e < N_ELEM; e++) elems[e] = {$urandom, $urandom, $urandom, $urandom};
    elem_i = 0; words0 = 0; words1 = 0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (elem_i >= N_ELEM && exp0.size() == 0 && exp1.size() == 0) break;
      @(negedge CLK);
      rst     = 1'b0;
      deq_rdy = (elem_i < N_ELEM) && ($urandom_range(3) != 0);
      first   = (elem_i < N_ELEM) ? elems[elem_i] : {4{$urandom}};
      enq_rdy = ($urandom_range(3) != 0);
      #1;
      if (deq_ena0 && !deq_rdy) chk("rnd lsb deq without rdy", 32'(deq_ena0), 32'd0);
      if (deq_ena1 && !deq_rdy) chk("rnd msb deq without rdy", 32'(deq_ena1), 32'd0);
      if (enq_ena0 && !enq_rdy) chk("rnd lsb enq without rdy", 32'(enq_ena0), 32'd0);
      if (enq_ena1 && !enq_rdy) chk("rnd msb enq without rdy", 32'(enq_ena1), 32'd0);
      if (deq_ena0 && elem_i < N_ELEM) begin
        for (int l = 0; l < 4; l++) begin
          exp0.push_back(first[32*l +: 32]);
          exp1.push_back(first[32*(3-l) +: 32]);
        end
        elem_i++;
      end
      if (enq_ena0) begin
        words0++;
        if (exp0.size() == 0) chk("rnd lsb extra word", v0, 32'hxxxxxxxx);
        else                  chk($sformatf("rnd lsb word%0d", words0), v0, exp0.pop_front());
      end
      if (enq_ena1) begin
        words1++;
        if (exp1.size() == 0) chk("rnd msb extra word", v1, 32'hxxxxxxxx);
        else                  chk($sformatf("rnd msb word%0d", words1), v1, exp1.pop_front());
      end
    end
    chk("rnd elements dequeued", 32'(elem_i), 32'(N_ELEM));
    chk("rnd lsb words emitted", 32'(words0), 32'(4*N_ELEM));
    chk("rnd msb words emitted", 32'(words1), 32'(4*N_ELEM));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
